// File: rtl/mem_pkg.sv
// Shared widths and client identifiers for the two-client memory port arbiter.
package mem_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 16;

  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_e;

  function automatic client_e other_client(input client_e c);
    return (c == CLIENT0) ? CLIENT1 : CLIENT0;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Client request/response and memory-side signals of the arbiter.
// The slave side is the arbiter; the master side is clients plus memory.
interface mem_port_arbiter_if
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          i_c0_req;
  logic          i_c0_we;
  logic [AW-1:0] i_c0_addr;
  logic [DW-1:0] i_c0_wdata;
  logic          o_c0_gnt;
  logic          o_c0_rvalid;
  logic [DW-1:0] o_c0_rdata;

  logic          i_c1_req;
  logic          i_c1_we;
  logic [AW-1:0] i_c1_addr;
  logic [DW-1:0] i_c1_wdata;
  logic          o_c1_gnt;
  logic          o_c1_rvalid;
  logic [DW-1:0] o_c1_rdata;

  logic          o_m_w_en;
  logic [AW-1:0] o_m_w_addr;
  logic [DW-1:0] o_m_d_in;
  logic [AW-1:0] o_m_r_addr;
  logic [DW-1:0] i_m_d_out;

  modport slave (
    input  i_c0_req, i_c0_we, i_c0_addr, i_c0_wdata,
    input  i_c1_req, i_c1_we, i_c1_addr, i_c1_wdata,
    input  i_m_d_out,
    output o_c0_gnt, o_c0_rvalid, o_c0_rdata,
    output o_c1_gnt, o_c1_rvalid, o_c1_rdata,
    output o_m_w_en, o_m_w_addr, o_m_d_in, o_m_r_addr
  );

  modport master (
    output i_c0_req, i_c0_we, i_c0_addr, i_c0_wdata,
    output i_c1_req, i_c1_we, i_c1_addr, i_c1_wdata,
    output i_m_d_out,
    input  o_c0_gnt, o_c0_rvalid, o_c0_rdata,
    input  o_c1_gnt, o_c1_rvalid, o_c1_rdata,
    input  o_m_w_en, o_m_w_addr, o_m_d_in, o_m_r_addr
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the grant is combinational, the pointer registered.
//   state   | meaning
//   CLIENT0 | client 0 wins the next contested cycle
//   CLIENT1 | client 1 wins the next contested cycle
module rr_arb2
  import mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  client_e prio_q;
  client_e prio_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) prio_q <= CLIENT0;
    else          prio_q <= prio_d;
  end

  // Only contention moves the pointer; a lone requester simply wins.
  always_comb begin
    gnt    = req;
    prio_d = prio_q;
    if (req == 2'b11) begin
      gnt    = (prio_q == CLIENT0) ? 2'b01 : 2'b10;
      prio_d = other_client(prio_q);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two clients onto a memory with independent write and read ports,
// with same-cycle write-to-read forwarding.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
)(
  input logic               i_clk,
  input logic               i_rst_n,
  mem_port_arbiter_if.slave bus
);
  logic [1:0]    wr_req;
  logic [1:0]    rd_req;
  logic [1:0]    wr_gnt;
  logic [1:0]    rd_gnt;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [AW-1:0] r_addr;
  logic [1:0]    rvalid_q;
  logic          fwd_q;
  logic [DW-1:0] fwd_data_q;
  logic [DW-1:0] rd_word;

  // Requests are masked by reset so no grant can leak out while it is held.
  always_comb begin
    wr_req = {bus.i_c1_req &  bus.i_c1_we, bus.i_c0_req &  bus.i_c0_we} & {2{i_rst_n}};
    rd_req = {bus.i_c1_req & ~bus.i_c1_we, bus.i_c0_req & ~bus.i_c0_we} & {2{i_rst_n}};
  end

  rr_arb2 u_wr_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .req     (wr_req),
    .gnt     (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .req     (rd_req),
    .gnt     (rd_gnt)
  );

  always_comb begin
    w_addr = '0;
    w_data = '0;
    if (wr_gnt[CLIENT0]) begin
      w_addr = bus.i_c0_addr;
      w_data = bus.i_c0_wdata;
    end else if (wr_gnt[CLIENT1]) begin
      w_addr = bus.i_c1_addr;
      w_data = bus.i_c1_wdata;
    end
  end

  always_comb begin
    r_addr = '0;
    if (rd_gnt[CLIENT0])      r_addr = bus.i_c0_addr;
    else if (rd_gnt[CLIENT1]) r_addr = bus.i_c1_addr;
  end

  // Memory returns pre-write data on a same-address collision, so capture the write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q   <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rvalid_q   <= rd_gnt;
      fwd_q      <= (|wr_gnt) && (|rd_gnt) && (w_addr == r_addr);
      fwd_data_q <= ((|wr_gnt) && (|rd_gnt) && (w_addr == r_addr)) ? w_data : '0;
    end
  end

  assign rd_word = fwd_q ? fwd_data_q : bus.i_m_d_out;

  assign bus.o_c0_gnt    = wr_gnt[CLIENT0] | rd_gnt[CLIENT0];
  assign bus.o_c1_gnt    = wr_gnt[CLIENT1] | rd_gnt[CLIENT1];
  assign bus.o_c0_rvalid = rvalid_q[CLIENT0];
  assign bus.o_c1_rvalid = rvalid_q[CLIENT1];
  assign bus.o_c0_rdata  = rvalid_q[CLIENT0] ? rd_word : '0;
  assign bus.o_c1_rdata  = rvalid_q[CLIENT1] ? rd_word : '0;

  assign bus.o_m_w_en   = |wr_gnt;
  assign bus.o_m_w_addr = w_addr;
  assign bus.o_m_d_in   = w_data;
  assign bus.o_m_r_addr = r_addr;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a reference model.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int MSZ = 1 << AW;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic [DW-1:0] pre(input int a);
    logic [DW-1:0] v;
    v = DW'(a * 257);
    return v ^ 16'h5A5A;
  endfunction

  // Memory macro stand-in: registered read, read-before-write on collision.
  logic [DW-1:0] phys_mem [MSZ];
  bit mem_loaded = 1'b0;
  always @(posedge i_clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MSZ; i++) phys_mem[i] <= pre(i);
      mem_loaded <= 1'b1;
    end else if (bus.o_m_w_en) begin
      phys_mem[bus.o_m_w_addr] <= bus.o_m_d_in;
    end
    bus.i_m_d_out <= phys_mem[bus.o_m_r_addr];
  end

  // Client stimulus
  logic          c_req   [2];
  logic          c_we    [2];
  logic [AW-1:0] c_addr  [2];
  logic [DW-1:0] c_wdata [2];

  task automatic apply();
    bus.i_c0_req = c_req[0]; bus.i_c0_we = c_we[0]; bus.i_c0_addr = c_addr[0]; bus.i_c0_wdata = c_wdata[0];
    bus.i_c1_req = c_req[1]; bus.i_c1_we = c_we[1]; bus.i_c1_addr = c_addr[1]; bus.i_c1_wdata = c_wdata[1];
  endtask

  task automatic set_client(input int n, input logic req, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_req[n] = req; c_we[n] = we; c_addr[n] = a; c_wdata[n] = d;
    apply();
  endtask

  task automatic idle_all();
    set_client(0, 1'b0, 1'b0, '0, '0);
    set_client(1, 1'b0, 1'b0, '0, '0);
  endtask

  // Reference model: favoured client per port, a plain memory array, pending read result
  logic [DW-1:0] ref_mem [MSZ];
  int            m_wr_fav, m_rd_fav;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_rdata;
  int            e_w, e_r;
  bit            e_wboth, e_rboth;
  logic [1:0]    e_gnt;
  logic          e_wen;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_din;

  task automatic model_reset();
    m_wr_fav = 0; m_rd_fav = 0; m_rv = 2'b00; m_rdata = '0;
  endtask

  task automatic model_eval();
    bit wr[2], rd[2];
    for (int n = 0; n < 2; n++) begin
      wr[n] = i_rst_n && c_req[n] &&  c_we[n];
      rd[n] = i_rst_n && c_req[n] && !c_we[n];
    end
    e_wboth = wr[0] && wr[1];
    e_rboth = rd[0] && rd[1];
    e_w = e_wboth ? m_wr_fav : (wr[0] ? 0 : (wr[1] ? 1 : -1));
    e_r = e_rboth ? m_rd_fav : (rd[0] ? 0 : (rd[1] ? 1 : -1));
    for (int n = 0; n < 2; n++) e_gnt[n] = (e_w == n) || (e_r == n);
    e_wen = (e_w >= 0);
    e_waddr = '0; e_din = '0; e_raddr = '0;
    if (e_w >= 0) begin e_waddr = c_addr[e_w]; e_din = c_wdata[e_w]; end
    if (e_r >= 0) e_raddr = c_addr[e_r];
  endtask

  task automatic model_commit();
    model_eval();
    m_rv = 2'b00;
    if (e_r >= 0) begin
      m_rv[e_r] = 1'b1;
      m_rdata = (e_wen && e_waddr == e_raddr) ? e_din : ref_mem[e_raddr];
    end
    if (e_wen) ref_mem[e_waddr] = e_din;
    if (e_wboth) m_wr_fav = 1 - e_w;
    if (e_rboth) m_rd_fav = 1 - e_r;
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    model_reset();
    idle_all();
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_client(0, 1'b1, 1'b1, 10'h001, 16'h1111);
    set_client(1, 1'b1, 1'b0, 10'h002, 16'h0000);
    #3;
    total_cnt++;
    if ({bus.o_c1_gnt, bus.o_c0_gnt, bus.o_m_w_en} !== 3'b000)
      $display("FAIL reset_hold gnt1/gnt0/w_en: got %b expected 000", {bus.o_c1_gnt, bus.o_c0_gnt, bus.o_m_w_en});
    else pass_cnt++;
    tick();
    tick();
    idle_all();
    i_rst_n = 1'b1;
    #3;
    total_cnt++;
    if ({bus.o_c1_gnt, bus.o_c0_gnt, bus.o_m_w_en} !== 3'b000)
      $display("FAIL reset_release gnt1/gnt0/w_en: got %b expected 000", {bus.o_c1_gnt, bus.o_c0_gnt, bus.o_m_w_en});
    else pass_cnt++;
    total_cnt++;
    if ({bus.o_c1_rvalid, bus.o_c0_rvalid} !== 2'b00)
      $display("FAIL reset_release rvalid: got %b expected 00", {bus.o_c1_rvalid, bus.o_c0_rvalid});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_write_then_read();
    set_client(0, 1'b1, 1'b1, 10'h005, 16'hABCD);
    #3;
    total_cnt++;
    if ({bus.o_c0_gnt, bus.o_m_w_en, bus.o_m_w_addr, bus.o_m_d_in} !== {1'b1, 1'b1, 10'h005, 16'hABCD})
      $display("FAIL wr_rd write gnt/w_en/addr/data: got %b %b %h %h expected 1 1 005 abcd",
               bus.o_c0_gnt, bus.o_m_w_en, bus.o_m_w_addr, bus.o_m_d_in);
    else pass_cnt++;
    tick();
    idle_all();
    set_client(1, 1'b1, 1'b0, 10'h005, 16'h0000);
    #3;
    total_cnt++;
    if ({bus.o_c1_gnt, bus.o_m_w_en, bus.o_m_r_addr} !== {1'b1, 1'b0, 10'h005})
      $display("FAIL wr_rd read gnt/w_en/r_addr: got %b %b %h expected 1 0 005",
               bus.o_c1_gnt, bus.o_m_w_en, bus.o_m_r_addr);
    else pass_cnt++;
    tick();
    idle_all();
    #3;
    total_cnt++;
    if ({bus.o_c1_rvalid, bus.o_c0_rvalid} !== 2'b10)
      $display("FAIL wr_rd rvalid: got %b expected 10", {bus.o_c1_rvalid, bus.o_c0_rvalid});
    else pass_cnt++;
    total_cnt++;
    if (bus.o_c1_rdata !== 16'hABCD)
      $display("FAIL wr_rd c1_rdata: got %h expected abcd", bus.o_c1_rdata);
    else pass_cnt++;
    tick();
    #3;
    total_cnt++;
    if ({bus.o_c1_rvalid, bus.o_c0_rvalid, bus.o_c1_rdata} !== {2'b00, 16'h0000})
      $display("FAIL wr_rd rvalid_drop: got %b %h expected 00 0000",
               {bus.o_c1_rvalid, bus.o_c0_rvalid}, bus.o_c1_rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_write_rr();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_client(0, 1'b1, 1'b1, 10'h010, 16'hC0C0);
      set_client(1, 1'b1, 1'b1, 10'h020, 16'hC1C1);
      #3;
      total_cnt++;
      if ({bus.o_c1_gnt, bus.o_c0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL wr_rr cycle %0d gnt: got %b expected %b", i,
                 {bus.o_c1_gnt, bus.o_c0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
      else pass_cnt++;
      total_cnt++;
      if ({bus.o_m_w_addr, bus.o_m_d_in} !== ((i % 2 == 0) ? {10'h010, 16'hC0C0} : {10'h020, 16'hC1C1}))
        $display("FAIL wr_rr cycle %0d addr/data: got %h %h", i, bus.o_m_w_addr, bus.o_m_d_in);
      else pass_cnt++;
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_same_cycle_fwd();
    set_client(0, 1'b1, 1'b1, 10'h3FF, 16'h1234);
    set_client(1, 1'b1, 1'b0, 10'h3FF, 16'h0000);
    #3;
    total_cnt++;
    if ({bus.o_c1_gnt, bus.o_c0_gnt, bus.o_m_w_addr, bus.o_m_r_addr} !== {2'b11, 10'h3FF, 10'h3FF})
      $display("FAIL fwd gnt/w_addr/r_addr: got %b %h %h expected 11 3ff 3ff",
               {bus.o_c1_gnt, bus.o_c0_gnt}, bus.o_m_w_addr, bus.o_m_r_addr);
    else pass_cnt++;
    tick();
    idle_all();
    #3;
    total_cnt++;
    if ({bus.o_c1_rvalid, bus.o_c0_rvalid} !== 2'b10)
      $display("FAIL fwd rvalid: got %b expected 10", {bus.o_c1_rvalid, bus.o_c0_rvalid});
    else pass_cnt++;
    total_cnt++;
    if (bus.o_c1_rdata !== 16'h1234)
      $display("FAIL fwd c1_rdata: got %h expected 1234", bus.o_c1_rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_read_rr();
    logic [1:0] rv_exp;
    logic [2*DW-1:0] rd_exp;
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        set_client(0, 1'b1, 1'b0, 10'h040, 16'h0000);
        set_client(1, 1'b1, 1'b0, 10'h080, 16'h0000);
      end else begin
        idle_all();
      end
      #3;
      if (i < 6) begin
        total_cnt++;
        if ({bus.o_c1_gnt, bus.o_c0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
          $display("FAIL rd_rr cycle %0d gnt: got %b expected %b", i,
                   {bus.o_c1_gnt, bus.o_c0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
        else pass_cnt++;
      end
      rv_exp = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
      rd_exp = (i == 0) ? '0 : (((i - 1) % 2 == 0) ? {16'h0000, pre(32'h040)} : {pre(32'h080), 16'h0000});
      total_cnt++;
      if ({bus.o_c1_rvalid, bus.o_c0_rvalid} !== rv_exp)
        $display("FAIL rd_rr cycle %0d rvalid: got %b expected %b", i, {bus.o_c1_rvalid, bus.o_c0_rvalid}, rv_exp);
      else pass_cnt++;
      total_cnt++;
      if ({bus.o_c1_rdata, bus.o_c0_rdata} !== rd_exp)
        $display("FAIL rd_rr cycle %0d rdata: got %h expected %h", i, {bus.o_c1_rdata, bus.o_c0_rdata}, rd_exp);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    set_client(0, 1'b1, 1'b0, 10'h040, 16'h0000);
    set_client(1, 1'b1, 1'b0, 10'h080, 16'h0000);
    #3;
    total_cnt++;
    if ({bus.o_c1_gnt, bus.o_c0_gnt} !== 2'b01)
      $display("FAIL rst_mid pre gnt: got %b expected 01", {bus.o_c1_gnt, bus.o_c0_gnt});
    else pass_cnt++;
    tick();
    set_client(0, 1'b1, 1'b0, 10'h040, 16'h0000);
    i_rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if ({bus.o_c1_rvalid, bus.o_c0_rvalid, bus.o_c1_gnt, bus.o_c0_gnt} !== 4'b0000)
      $display("FAIL rst_mid during rvalid/gnt: got %b expected 0000",
               {bus.o_c1_rvalid, bus.o_c0_rvalid, bus.o_c1_gnt, bus.o_c0_gnt});
    else pass_cnt++;
    tick();
    i_rst_n = 1'b1;
    #3;
    total_cnt++;
    if ({bus.o_c1_rvalid, bus.o_c0_rvalid} !== 2'b00)
      $display("FAIL rst_mid release rvalid: got %b expected 00", {bus.o_c1_rvalid, bus.o_c0_rvalid});
    else pass_cnt++;
    total_cnt++;
    if ({bus.o_c1_gnt, bus.o_c0_gnt} !== 2'b01)
      $display("FAIL rst_mid pointer gnt: got %b expected 01", {bus.o_c1_gnt, bus.o_c0_gnt});
    else pass_cnt++;
    tick();
    idle_all();
    #3;
    total_cnt++;
    if ({bus.o_c1_rvalid, bus.o_c0_rvalid, bus.o_c0_rdata} !== {2'b01, pre(32'h040)})
      $display("FAIL rst_mid post read: got %b %h expected 01 %h",
               {bus.o_c1_rvalid, bus.o_c0_rvalid}, bus.o_c0_rdata, pre(32'h040));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [1:0] rv_dut;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(c_req[n] && !e_gnt[n])) begin
          c_req[n]   = ($urandom_range(0, 3) != 0);
          c_we[n]    = $urandom_range(0, 1) == 1;
          c_addr[n]  = AW'($urandom_range(0, 7));
          c_wdata[n] = DW'($urandom);
        end
      end
      apply();
      #3;
      model_eval();
      total_cnt++;
      if ({bus.o_c1_gnt, bus.o_c0_gnt} !== e_gnt)
        $display("FAIL rand cyc %0d gnt: got %b expected %b", cyc, {bus.o_c1_gnt, bus.o_c0_gnt}, e_gnt);
      else pass_cnt++;
      total_cnt++;
      if ({bus.o_m_w_en, bus.o_m_w_addr, bus.o_m_d_in} !== {e_wen, e_waddr, e_din})
        $display("FAIL rand cyc %0d write port: got %b %h %h expected %b %h %h", cyc,
                 bus.o_m_w_en, bus.o_m_w_addr, bus.o_m_d_in, e_wen, e_waddr, e_din);
      else pass_cnt++;
      total_cnt++;
      if (bus.o_m_r_addr !== e_raddr)
        $display("FAIL rand cyc %0d r_addr: got %h expected %h", cyc, bus.o_m_r_addr, e_raddr);
      else pass_cnt++;
      rv_dut = {bus.o_c1_rvalid, bus.o_c0_rvalid};
      total_cnt++;
      if (rv_dut !== m_rv)
        $display("FAIL rand cyc %0d rvalid: got %b expected %b", cyc, rv_dut, m_rv);
      else pass_cnt++;
      total_cnt++;
      if (bus.o_c0_rdata !== (m_rv[0] ? m_rdata : '0))
        $display("FAIL rand cyc %0d c0_rdata: got %h expected %h", cyc, bus.o_c0_rdata, m_rv[0] ? m_rdata : '0);
      else pass_cnt++;
      total_cnt++;
      if (bus.o_c1_rdata !== (m_rv[1] ? m_rdata : '0))
        $display("FAIL rand cyc %0d c1_rdata: got %h expected %h", cyc, bus.o_c1_rdata, m_rv[1] ? m_rdata : '0);
      else pass_cnt++;
      tick();
    end
    idle_all();
    tick();
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) ref_mem[i] = pre(i);
    model_reset();
    e_gnt = 2'b00;
    idle_all();
    i_rst_n = 1'b0;
    #1;
    test_reset();
    test_write_then_read();
    test_write_rr();
    test_same_cycle_fwd();
    test_read_rr();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
